// File: rtl/spi_xfer_pkg.sv
// spi_xfer_pkg: shared state encoding and config-word field layout for spi_xfer_ctrl
package spi_xfer_pkg;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_CAPTURE, S_GAP, S_ERROR} state_t;
   localparam int CR1_MSB = 31;
   localparam int CR1_LSB = 24;
   localparam int CR2_MSB = 23;
   localparam int CR2_LSB = 16;
   localparam int SR_MSB = 15;
   localparam int SR_LSB = 8;
   localparam int BR_MSB = 7;
   localparam int BR_LSB = 0;
   localparam int CR1_SPIE = 7;
   localparam int CR1_SPE = 6;
   localparam int CR1_MSTR = 4;
   localparam int CR1_CPOL = 3;
   localparam int CR1_CPHA = 2;
   localparam int CR1_LSBFE = 0;
   function automatic logic [7:0] cfg_cr1(input logic [31:0] cfg);
      return cfg[CR1_MSB:CR1_LSB];
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; simultaneous push and pop are both honoured, even when full
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   assign full = cnt_q == CW'(DEPTH);
   assign empty = cnt_q == '0;
   assign count = cnt_q;
   assign dout = empty ? '0 : mem_q[rd_q];
   assign do_push = push && (!full || pop);
   assign do_pop = pop && !empty;
   // next storage, wrapping pointers and occupancy
   always_comb begin
      mem_d = mem_q;
      if (do_push) mem_d[wr_q] = din;
      wr_d = do_push ? wr_q + AW'(1) : wr_q;
      rd_d = do_pop ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q + (do_push ? CW'(1) : '0) - (do_pop ? CW'(1) : '0);
   end
   // state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '{default: '0};
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: sequences TX bytes through the SPI core and collects replies; optional SPI_XFER_TIMEOUT_EN
module spi_xfer_ctrl
   import spi_xfer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        i_sys_clk,
   input  logic        i_sys_rst,
   input  logic [31:0] i_cfg,
   input  logic        i_tx_valid,
   input  logic [7:0]  i_tx_data,
   output logic        o_tx_ready,
   output logic        o_rx_valid,
   output logic [7:0]  o_rx_data,
   input  logic        i_rx_ready,
   output logic [31:0] o_data_config,
   output logic        o_trans_en,
   output logic [7:0]  o_spi_data,
   input  logic [7:0]  i_spi_data,
   input  logic        i_spi_done,
   input  logic        i_spi_irq,
   input  logic        i_err_clr,
   output logic        o_busy,
   output logic        o_err
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
   state_t state_q, state_d;
   logic [31:0] cfg_q, cfg_d;
   logic [7:0] spi_q, spi_d;
   logic err_q, err_d;
   logic [GW-1:0] gap_q, gap_d;
   logic tx_full, tx_empty, rx_empty, tx_push, tx_pop, rx_push, rx_pop, tmo_hit;
   logic rx_full_unused;
   logic [7:0] tx_dout;
   logic [CW-1:0] rx_cnt, tx_cnt_unused;
   assign o_tx_ready = !tx_full;
   assign o_rx_valid = !rx_empty;
   assign o_data_config = cfg_q;
   assign o_spi_data = spi_q;
   assign o_err = err_q;
   assign o_busy = state_q != S_IDLE;
   assign o_trans_en = state_q == S_START;
   assign tx_push = i_tx_valid && o_tx_ready;
   assign tx_pop = state_q == S_LOAD;
   assign rx_push = state_q == S_CAPTURE && !i_spi_irq;
   assign rx_pop = i_rx_ready && o_rx_valid;
   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx (
      .clk(i_sys_clk), .rst(i_sys_rst), .push(tx_push), .din(i_tx_data), .pop(tx_pop),
      .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_cnt_unused)
   );
   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx (
      .clk(i_sys_clk), .rst(i_sys_rst), .push(rx_push), .din(i_spi_data), .pop(rx_pop),
      .dout(o_rx_data), .full(rx_full_unused), .empty(rx_empty), .count(rx_cnt)
   );
`ifdef SPI_XFER_TIMEOUT_EN
   localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] tmo_q, tmo_d;
   assign tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES - 1);
   // WAIT watchdog; zero everywhere else so each WAIT starts from 0
   always_comb tmo_d = state_q == S_WAIT ? tmo_q + TW'(1) : '0;
   // watchdog register
   always_ff @(posedge i_sys_clk) tmo_q <= i_sys_rst ? '0 : tmo_d;
`else
   logic unused_tmo;
   assign tmo_hit = 1'b0;
   assign unused_tmo = ^TIMEOUT_CYCLES;
`endif
   // frame sequencing; an interrupt anywhere outside IDLE overrides the normal next state
   always_comb begin
      state_d = state_q;
      cfg_d = cfg_q;
      spi_d = spi_q;
      err_d = err_q;
      gap_d = '0;
      case (state_q)
         S_IDLE:    if (!tx_empty && rx_cnt < CW'(DEPTH) && !err_q) state_d = S_LOAD;
         S_LOAD:    begin
            state_d = S_START;
            cfg_d = i_cfg;
            spi_d = tx_dout;
         end
         S_START:   state_d = S_WAIT;
         S_WAIT:    begin
            state_d = i_spi_done ? S_CAPTURE : tmo_hit ? S_ERROR : S_WAIT;
            err_d = !i_spi_done && tmo_hit;
         end
         S_CAPTURE: state_d = GAP_CYCLES == 0 ? S_IDLE : S_GAP;
         S_GAP:     begin
            state_d = gap_q == GW'(GAP_CYCLES - 1) ? S_IDLE : S_GAP;
            gap_d = gap_q == GW'(GAP_CYCLES - 1) ? '0 : gap_q + GW'(1);
         end
         S_ERROR:   begin
            state_d = i_err_clr ? S_IDLE : S_ERROR;
            err_d = !i_err_clr;
         end
         default:   state_d = S_IDLE;
      endcase
      if (state_q != S_IDLE && i_spi_irq) begin
         state_d = S_ERROR;
         err_d = 1'b1;
      end
   end
   // state, held config/byte and error registers
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         state_q <= S_IDLE;
         cfg_q <= '0;
         spi_q <= '0;
         err_q <= 1'b0;
         gap_q <= '0;
      end else begin
         state_q <= state_d;
         cfg_q <= cfg_d;
         spi_q <= spi_d;
         err_q <= err_d;
         gap_q <= gap_d;
      end
   end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: scoreboard bench with an SPI core responder model and randomized traffic
module tb_spi_xfer_ctrl;
   localparam int DEPTH = 4;
   localparam int GAP = 2;
   localparam int TMO = 16;
   logic clk = 1'b0;
   logic rst;
   logic [31:0] cfg, cfg_host, cfg_xor;
   logic tx_valid, tx_ready, rx_valid, rx_ready, trans_en, done, irq, err_clr, busy, err;
   logic [7:0] tx_data, rx_data, spi_out, spi_in;
   logic [31:0] data_config;
   int tests = 0, fails = 0;
   int cyc = 0, trans_cnt = 0, rx_cnt = 0, core_frames = 0;
   int fixed_lat = 0, irq_frame = -1, cfg_frame = -1, done_cyc = 0;
   int rx_mode = 1, pop_req = 0, pop_served = 0;
   bit no_done = 0, fixed_resp_en = 0, have_done = 0, prev_te = 0;
   logic [7:0] fixed_resp = 8'h00, last_exp_byte = 8'h00;
   logic [7:0] exp_tx[$];
   logic [7:0] exp_rx[$];

   assign cfg = cfg_host ^ cfg_xor;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_xfer_ctrl #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
      .i_sys_clk(clk), .i_sys_rst(rst), .i_cfg(cfg), .i_tx_valid(tx_valid), .i_tx_data(tx_data),
      .o_tx_ready(tx_ready), .o_rx_valid(rx_valid), .o_rx_data(rx_data), .i_rx_ready(rx_ready),
      .o_data_config(data_config), .o_trans_en(trans_en), .o_spi_data(spi_out), .i_spi_data(spi_in),
      .i_spi_done(done), .i_spi_irq(irq), .i_err_clr(err_clr), .o_busy(busy), .o_err(err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_tx(input logic [7:0] b);
      int n = 0;
      while (!tx_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!tx_ready) check("tx_ready_wait", 0, 1);
      else begin
         tx_valid = 1'b1;
         tx_data = b;
         exp_tx.push_back(b);
         @(negedge clk);
         tx_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || rx_valid || exp_tx.size() != 0 || exp_rx.size() != 0) && n < 3000);
      check(name, 32'(n < 3000), 1);
   endtask

   task automatic wait_trans(input int target);
      int n = 0;
      while (trans_cnt < target && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("trans_wait", 32'(trans_cnt >= target), 1);
   endtask

   // host RX side: hold low, hold high, random, or serve single pops on request
   always @(posedge clk) begin
      #1;
      case (rx_mode)
         0: rx_ready = 1'b0;
         1: rx_ready = 1'b1;
         2: rx_ready = 1'($urandom);
         default: begin
            rx_ready = pop_served < pop_req;
            if (pop_served < pop_req) pop_served++;
         end
      endcase
   end

   // start monitor: each transfer pulse must carry the next host byte and the current config
   always @(negedge clk) begin
      if (trans_en) begin
         trans_cnt++;
         check("trans_en_single", 32'(prev_te), 0);
         if (exp_tx.size() == 0) check("tx_unexpected", 32'(spi_out), 32'hFFFF_FFFF);
         else begin
            last_exp_byte = exp_tx.pop_front();
            check("spi_byte", 32'(spi_out), 32'(last_exp_byte));
         end
         check("start_cfg", data_config, cfg);
         check("start_no_err", 32'(err), 0);
         if (have_done) check("frame_spacing", 32'(cyc - done_cyc >= GAP + 4), 1);
      end
      prev_te = trans_en;
   end

   // RX monitor: every popped byte must be the oldest reply the core model produced
   always @(negedge clk) begin
      if (rx_valid && rx_ready) begin
         rx_cnt++;
         if (exp_rx.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
         else check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
   end

   // SPI core model: answers each transfer after a latency, optionally faulting or changing config
   initial begin
      int l;
      logic [7:0] r, sb;
      logic [31:0] sc;
      done = 1'b0;
      irq = 1'b0;
      spi_in = 8'h00;
      cfg_xor = 32'h0;
      forever begin
         @(negedge clk);
         if (trans_en) begin
            core_frames++;
            sc = cfg;
            #1;
            sb = last_exp_byte;
            if (!no_done) begin
               l = fixed_lat > 0 ? fixed_lat : int'($urandom_range(1, 8));
               r = fixed_resp_en ? fixed_resp : 8'($urandom);
               for (int i = 0; i < l; i++) begin
                  @(posedge clk);
                  #1;
                  if (i == 0 && core_frames == cfg_frame) cfg_xor = cfg_xor ^ 32'hA5A5_0F0F;
               end
               check("cfg_hold", data_config, sc);
               check("byte_hold", 32'(spi_out), 32'(sb));
               done = 1'b1;
               spi_in = r;
               irq = core_frames == irq_frame;
               if (core_frames == irq_frame) have_done = 0;
               else begin
                  exp_rx.push_back(r);
                  done_cyc = cyc;
                  have_done = 1;
               end
               @(posedge clk);
               #1;
               done = 1'b0;
               irq = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, k;
      rst = 1'b1;
      tx_valid = 1'b0;
      tx_data = 8'h00;
      err_clr = 1'b0;
      cfg_host = 32'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_tx_ready", 32'(tx_ready), 1);
      check("rst_rx_valid", 32'(rx_valid), 0);
      check("rst_rx_data", 32'(rx_data), 0);
      check("rst_cfg", data_config, 0);
      check("rst_trans_en", 32'(trans_en), 0);
      check("rst_spi_data", 32'(spi_out), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_err", 32'(err), 0);

      // single byte with known latency and reply
      cfg_host = 32'h5C00_0000;
      fixed_lat = 10;
      fixed_resp_en = 1;
      fixed_resp = 8'h3C;
      base = trans_cnt;
      push_tx(8'hA5);
      wait_idle("single_drain");
      check("single_trans", 32'(trans_cnt - base), 1);
      check("single_rx_cnt", 32'(rx_cnt), 1);
      check("single_cfg", data_config, 32'h5C00_0000);
      check("single_spi", 32'(spi_out), 32'hA5);
      fixed_resp_en = 0;

      // burst: fill TX while a slow frame is in flight
      fixed_lat = 30;
      rx_mode = 2;
      base = trans_cnt;
      push_tx(8'h00);
      wait_trans(base + 1);
      fixed_lat = 0;
      for (int i = 1; i <= 4; i++) push_tx(8'(i));
      check("burst_tx_full", 32'(tx_ready), 0);
      wait_idle("burst_drain");
      check("burst_trans", 32'(trans_cnt - base), 5);

      // RX backpressure: four frames fill RX, then one pop allows exactly one more
      rx_mode = 0;
      base = trans_cnt;
      for (int i = 0; i < 6; i++) push_tx(8'($urandom));
      repeat (100) @(negedge clk);
      check("bp_trans4", 32'(trans_cnt - base), 4);
      check("bp_busy", 32'(busy), 0);
      check("bp_rx_valid", 32'(rx_valid), 1);
      pop_req++;
      rx_mode = 3;
      repeat (100) @(negedge clk);
      check("bp_trans5", 32'(trans_cnt - base), 5);
      check("bp_busy2", 32'(busy), 0);
      rx_mode = 2;
      wait_idle("bp_drain");
      check("bp_trans6", 32'(trans_cnt - base), 6);

      // config change while waiting for end-of-frame
      cfg_host = 32'h1234_5678;
      cfg_frame = core_frames + 1;
      base = trans_cnt;
      push_tx(8'h11);
      push_tx(8'h22);
      wait_idle("cfg_drain");
      check("cfg_trans", 32'(trans_cnt - base), 2);
      check("cfg_new", data_config, 32'h1234_5678 ^ 32'hA5A5_0F0F);

      // fault: interrupt coincident with done
      fixed_lat = 5;
      irq_frame = core_frames + 1;
      base = trans_cnt;
      k = rx_cnt;
      push_tx(8'h31);
      push_tx(8'h32);
      push_tx(8'h33);
      repeat (40) @(negedge clk);
      check("fault_err", 32'(err), 1);
      check("fault_busy", 32'(busy), 1);
      check("fault_trans", 32'(trans_cnt - base), 1);
      check("fault_no_rx", 32'(rx_valid), 0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("fault_cleared", 32'(err), 0);
      wait_idle("fault_drain");
      check("fault_resume", 32'(trans_cnt - base), 3);
      check("fault_rx_cnt", 32'(rx_cnt - k), 2);
      fixed_lat = 0;

      // end-of-frame never arrives
      no_done = 1;
      base = trans_cnt;
      push_tx(8'h44);
      k = 0;
      while (!trans_en && k < 500) begin
         @(negedge clk);
         k++;
      end
      check("tmo_started", 32'(trans_en), 1);
`ifdef SPI_XFER_TIMEOUT_EN
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!err && k < 200);
      check("tmo_cycles", 32'(k), 32'(TMO + 1));
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("tmo_cleared", 32'(err), 0);
`else
      repeat (1000) @(negedge clk);
      check("tmo_still_busy", 32'(busy), 1);
      check("tmo_no_err", 32'(err), 0);
      check("tmo_one_frame", 32'(trans_cnt - base), 1);
`endif
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      no_done = 0;
      check("rst2_busy", 32'(busy), 0);
      check("rst2_cfg", data_config, 0);
      check("rst2_tx_ready", 32'(tx_ready), 1);
      repeat (20) @(negedge clk);
      check("rst2_no_frame", 32'(trans_cnt - base), 1);
      check("exp_tx_empty", 32'(exp_tx.size()), 0);
      check("exp_rx_empty", 32'(exp_rx.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
